// File: rtl/upc_loop_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : upc_loop_status_monitor
// Purpose  : Passive status monitor for one HLS block containing a single
//            pipelined loop (II=1, DEPTH stages). Counts block transactions,
//            their start-to-done latency, and loop iteration start, end and
//            quit events for on-chip debug. Never drives the monitored block.
// Options  : define STALL_COUNT_EN to add the stall_cycles output, which
//            counts busy cycles where the iteration-start stage is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module upc_loop_status_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32,
    parameter int DEPTH   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_done,
    input  logic               quit_at_end,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   last_txn_latency,
    output logic [CNT_W-1:0]   iter_started,
    output logic [CNT_W-1:0]   iter_ended,
    output logic [CNT_W-1:0]   in_flight,
    output logic [CNT_W-1:0]   loop_quits,
`ifdef STALL_COUNT_EN
    output logic [CNT_W-1:0]   stall_cycles,
`endif
    output logic               frozen
);

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // The last-stage enable only makes sense for a pipeline of at least one stage.
    if (DEPTH < 1) begin : g_depth_check
        $error("upc_loop_status_monitor: DEPTH must be at least 1");
    end

    // ap_ready is part of the observed handshake but carries no information
    // the counters need; it is kept on the port list for a uniform hookup.
    logic w_unused_ready;
    assign w_unused_ready = ap_ready;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAITC = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] w_lat_nxt;
    logic             w_commit;
    logic [CNT_W-1:0] w_commit_lat;

    logic             r_frozen;
    logic             w_hold;
    logic             w_evt_s;
    logic             w_evt_e;
    logic             w_evt_q;

    logic [CNT_W-1:0] r_txn_count;
    logic [CNT_W-1:0] r_last_lat;
    logic [CNT_W-1:0] r_iter_started;
    logic [CNT_W-1:0] r_iter_ended;
    logic [CNT_W-1:0] r_in_flight;
    logic [CNT_W-1:0] r_loop_quits;

    // Finish takes effect in the cycle it is seen, then stays via r_frozen.
    assign w_hold = r_frozen | finish;

    // Loop events decoded from the block's FSM state and stage handshakes.
    assign w_evt_s = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
    assign w_evt_e = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
    assign w_evt_q = quit_at_end ? (w_evt_e & loop_done)
                                 : ((cur_state == quit_state) & ~quit_block & quit_enable);

    // Transaction FSM: next state, latency tracking and commit decision.
    // The latency counter holds the number of cycles elapsed since ap_start
    // (the start cycle counts as 1), so a done seen in RUN commits r_lat+1.
    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat;
        w_commit     = 1'b0;
        w_commit_lat = r_lat;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_lat_nxt = c_one;
                    if (ap_done) begin
                        // Zero-latency transaction: start and done together.
                        if (ap_continue) begin
                            w_commit     = 1'b1;
                            w_commit_lat = c_one;
                        end else begin
                            w_state_nxt = ST_WAITC;
                        end
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_lat_nxt = r_lat + c_one;
                if (ap_done) begin
                    if (ap_continue) begin
                        w_commit     = 1'b1;
                        w_commit_lat = r_lat + c_one;
                        if (ap_start) begin
                            // Back-to-back: a new transaction starts this cycle.
                            w_state_nxt = ST_RUN;
                            w_lat_nxt   = c_one;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        // Latency is frozen at done while waiting for continue.
                        w_state_nxt = ST_WAITC;
                    end
                end
            end
            ST_WAITC: begin
                if (ap_continue) begin
                    w_commit     = 1'b1;
                    w_commit_lat = r_lat;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latency and sticky frozen flag; everything holds once frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_lat    <= '0;
            r_frozen <= 1'b0;
        end else begin
            if (finish) begin
                r_frozen <= 1'b1;
            end
            if (!w_hold) begin
                r_state <= w_state_nxt;
                r_lat   <= w_lat_nxt;
            end
        end
    end

    // Transaction counters, updated on each commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_txn_count <= '0;
            r_last_lat  <= '0;
        end else if (!w_hold && w_commit) begin
            r_txn_count <= r_txn_count + c_one;
            r_last_lat  <= w_commit_lat;
        end
    end

    // Iteration counters; these wrap modulo 2^CNT_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_iter_started <= '0;
            r_iter_ended   <= '0;
            r_loop_quits   <= '0;
        end else if (!w_hold) begin
            if (w_evt_s) begin
                r_iter_started <= r_iter_started + c_one;
            end
            if (w_evt_e) begin
                r_iter_ended <= r_iter_ended + c_one;
            end
            if (w_evt_q) begin
                r_loop_quits <= r_loop_quits + c_one;
            end
        end
    end

    // Pipeline occupancy, saturating at both ends instead of wrapping.
    // A start and an end in the same cycle leave occupancy unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_flight <= '0;
        end else if (!w_hold) begin
            if (w_evt_s && !w_evt_e) begin
                if (r_in_flight != c_cnt_max) begin
                    r_in_flight <= r_in_flight + c_one;
                end
            end else if (w_evt_e && !w_evt_s) begin
                if (r_in_flight != '0) begin
                    r_in_flight <= r_in_flight - c_one;
                end
            end
        end
    end

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_stall;

    assign w_stall = (r_state != ST_IDLE) & (cur_state == iter_start_state) & iter_start_block;

    // Count busy cycles in which the iteration-start stage is held off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (!w_hold && w_stall) begin
            r_stall_cycles <= r_stall_cycles + c_one;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign busy             = (r_state != ST_IDLE);
    assign txn_count        = r_txn_count;
    assign last_txn_latency = r_last_lat;
    assign iter_started     = r_iter_started;
    assign iter_ended       = r_iter_ended;
    assign in_flight        = r_in_flight;
    assign loop_quits       = r_loop_quits;
    assign frozen           = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_upc_loop_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_upc_loop_status_monitor
// Purpose  : Directed self-checking bench for upc_loop_status_monitor. A
//            32-bit instance carries the main checks; a 4-bit instance shares
//            the same stimulus to exercise counter wrap and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upc_loop_status_monitor;

    logic       clock;
    logic       reset;
    logic       finish;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic       ap_continue;
    logic [0:0] cur_state;
    logic [0:0] iter_start_state;
    logic [0:0] iter_end_state;
    logic [0:0] quit_state;
    logic       iter_start_block;
    logic       iter_end_block;
    logic       quit_block;
    logic       iter_start_enable;
    logic       iter_end_enable;
    logic       quit_enable;
    logic       loop_done;
    logic       quit_at_end;

    logic        busy;
    logic [31:0] txn_count;
    logic [31:0] last_txn_latency;
    logic [31:0] iter_started;
    logic [31:0] iter_ended;
    logic [31:0] in_flight;
    logic [31:0] loop_quits;
    logic        frozen;

    logic       s_busy;
    logic [3:0] s_txn_count;
    logic [3:0] s_last_txn_latency;
    logic [3:0] s_iter_started;
    logic [3:0] s_iter_ended;
    logic [3:0] s_in_flight;
    logic [3:0] s_loop_quits;
    logic       s_frozen;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [3:0]  s_stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    upc_loop_status_monitor #(.STATE_W(1), .CNT_W(32), .DEPTH(5)) u_dut (
        .clock             (clock),
        .reset             (reset),
        .finish            (finish),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .quit_state        (quit_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .quit_block        (quit_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .quit_enable       (quit_enable),
        .loop_done         (loop_done),
        .quit_at_end       (quit_at_end),
        .busy              (busy),
        .txn_count         (txn_count),
        .last_txn_latency  (last_txn_latency),
        .iter_started      (iter_started),
        .iter_ended        (iter_ended),
        .in_flight         (in_flight),
        .loop_quits        (loop_quits),
`ifdef STALL_COUNT_EN
        .stall_cycles      (stall_cycles),
`endif
        .frozen            (frozen)
    );

    upc_loop_status_monitor #(.STATE_W(1), .CNT_W(4), .DEPTH(5)) u_dut_small (
        .clock             (clock),
        .reset             (reset),
        .finish            (finish),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .quit_state        (quit_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .quit_block        (quit_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .quit_enable       (quit_enable),
        .loop_done         (loop_done),
        .quit_at_end       (quit_at_end),
        .busy              (s_busy),
        .txn_count         (s_txn_count),
        .last_txn_latency  (s_last_txn_latency),
        .iter_started      (s_iter_started),
        .iter_ended        (s_iter_ended),
        .in_flight         (s_in_flight),
        .loop_quits        (s_loop_quits),
`ifdef STALL_COUNT_EN
        .stall_cycles      (s_stall_cycles),
`endif
        .frozen            (s_frozen)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_main(input string tag, input logic exp_busy, input int exp_txn,
                              input int exp_lat, input int exp_st, input int exp_en,
                              input int exp_inf, input int exp_q, input logic exp_frz);
        check({tag, "_busy"},    32'(busy),             32'(exp_busy));
        check({tag, "_txn"},     txn_count,             32'(exp_txn));
        check({tag, "_lat"},     last_txn_latency,      32'(exp_lat));
        check({tag, "_started"}, iter_started,          32'(exp_st));
        check({tag, "_ended"},   iter_ended,            32'(exp_en));
        check({tag, "_inflt"},   in_flight,             32'(exp_inf));
        check({tag, "_quits"},   loop_quits,            32'(exp_q));
        check({tag, "_frozen"},  32'(frozen),           32'(exp_frz));
    endtask

    // One clock: inputs set beforehand are sampled at the edge; outputs
    // are read 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        finish            = 1'b0;
        ap_start          = 1'b0;
        ap_ready          = 1'b0;
        ap_done           = 1'b0;
        ap_continue       = 1'b1;
        cur_state         = 1'b0;
        iter_start_state  = 1'b0;
        iter_end_state    = 1'b0;
        quit_state        = 1'b0;
        iter_start_block  = 1'b0;
        iter_end_block    = 1'b0;
        quit_block        = 1'b0;
        iter_start_enable = 1'b0;
        iter_end_enable   = 1'b0;
        quit_enable       = 1'b0;
        loop_done         = 1'b0;
        quit_at_end       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset held with random activity on every input.
        for (int i = 0; i < 6; i++) begin
            {finish, ap_start, ap_ready, ap_done, ap_continue} = 5'($urandom);
            {cur_state, iter_start_state, iter_end_state, quit_state} = 4'($urandom);
            {iter_start_block, iter_end_block, quit_block} = 3'($urandom);
            {iter_start_enable, iter_end_enable, quit_enable, loop_done, quit_at_end} = 5'($urandom);
            tick();
        end
        check_main("rst_hold", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        check("rst_hold_small_started", 32'(s_iter_started), 32'd0);
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_main("rst_rel", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

        // Pipeline run: start at 0, S on 1..8, E on 5..12, Q on 12, done on 13.
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            ap_start          = (c == 0);
            iter_start_enable = (c >= 1 && c <= 8);
            iter_end_enable   = (c >= 5 && c <= 12);
            quit_enable       = (c == 12);
            ap_done           = (c == 13);
            tick();
            if (c == 0) begin
                check("pipe_busy_c0", 32'(busy), 32'd1);
            end
            if (c == 6) begin
                check("pipe_mid_inflt", in_flight, 32'd4);
                check("pipe_mid_started", iter_started, 32'd6);
                check("pipe_mid_ended", iter_ended, 32'd2);
            end
        end
        idle_inputs();
        check_main("pipe", 1'b0, 1, 14, 8, 8, 0, 1, 1'b0);

        // Quit-at-end: quit-stage path ignored, quit on E with loop_done.
        do_reset();
        quit_at_end = 1'b1;
        quit_enable = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            ap_start          = (c == 0);
            iter_start_enable = (c >= 1 && c <= 3);
            iter_end_enable   = (c >= 2 && c <= 4);
            loop_done         = (c == 1 || c == 4);
            ap_done           = (c == 5);
            tick();
        end
        idle_inputs();
        check_main("qend", 1'b0, 1, 6, 3, 3, 0, 1, 1'b0);

        // Start stage stalled on cycles 3..5; then S&E together; then extra E.
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            ap_start          = (c == 0);
            iter_start_enable = (c >= 1 && c <= 6);
            iter_start_block  = (c >= 3 && c <= 5);
            ap_done           = (c == 7);
            tick();
        end
        idle_inputs();
        check_main("stall", 1'b0, 1, 8, 3, 0, 3, 0, 1'b0);
`ifdef STALL_COUNT_EN
        check("stall_cycles", stall_cycles, 32'd3);
`endif
        iter_start_enable = 1'b1;
        iter_end_enable   = 1'b1;
        tick();
        idle_inputs();
        check("se_same_started", iter_started, 32'd4);
        check("se_same_ended", iter_ended, 32'd1);
        check("se_same_inflt", in_flight, 32'd3);
        iter_end_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle_inputs();
        check("sat0_ended", iter_ended, 32'd6);
        check("sat0_inflt", in_flight, 32'd0);

        // Continue low for two done cycles, then high.
        do_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        ap_done     = 1'b1;
        ap_continue = 1'b0;
        tick();
        check("cont_lo1_busy", 32'(busy), 32'd1);
        check("cont_lo1_txn", txn_count, 32'd0);
        tick();
        check("cont_lo2_busy", 32'(busy), 32'd1);
        check("cont_lo2_txn", txn_count, 32'd0);
        ap_done     = 1'b0;
        ap_continue = 1'b1;
        tick();
        check("cont_hi_busy", 32'(busy), 32'd0);
        check("cont_hi_txn", txn_count, 32'd1);
        check("cont_hi_lat", last_txn_latency, 32'd4);

        // Zero-latency transaction from IDLE.
        ap_start = 1'b1;
        ap_done  = 1'b1;
        tick();
        idle_inputs();
        check("zlat_busy", 32'(busy), 32'd0);
        check("zlat_txn", txn_count, 32'd2);
        check("zlat_lat", last_txn_latency, 32'd1);

        // Finish mid-loop freezes everything, FSM included.
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            ap_start          = (c == 0);
            iter_start_enable = (c >= 1);
            tick();
        end
        idle_inputs();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int c = 0; c < 4; c++) begin
            iter_start_enable = 1'b1;
            iter_end_enable   = (c >= 1);
            quit_enable       = (c == 3);
            ap_done           = (c == 3);
            tick();
        end
        idle_inputs();
        check_main("frz", 1'b1, 0, 0, 3, 0, 3, 0, 1'b1);

        // Reset during a frozen, busy transaction discards it.
        do_reset();
        check_main("rst_mid", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

        // Wrap and saturation with the 4-bit instance: 17 starts.
        iter_start_enable = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        idle_inputs();
        check("wrap_small_started", 32'(s_iter_started), 32'd1);
        check("wrap_small_inflt", 32'(s_in_flight), 32'd15);
        check("wrap_big_started", iter_started, 32'd17);
        check("wrap_big_inflt", in_flight, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
